// File: rtl/bus_arbiter_if.sv
// Shared-bus arbiter port bundle: four requester words and valids in,
// one granted word plus grant/status out.
interface bus_arbiter_if;
  logic [63:0] i_bus0;
  logic [63:0] i_bus1;
  logic [63:0] i_bus2;
  logic [63:0] i_bus3;
  logic [3:0]  i_vld;
  logic [3:0]  o_gnt;
  logic [63:0] o_bus;
  logic        o_bus_vld;
  logic        o_busy;
  logic [1:0]  o_owner;

  modport slave (
    input  i_bus0, i_bus1, i_bus2, i_bus3, i_vld,
    output o_gnt, o_bus, o_bus_vld, o_busy, o_owner
  );

  modport master (
    output i_bus0, i_bus1, i_bus2, i_bus3, i_vld,
    input  o_gnt, o_bus, o_bus_vld, o_busy, o_owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-port round-robin bus arbiter with interrupt priority. The winner's word
// is latched and held on the bus for reqCycles+1 cycles, followed by a turnaround.
module bus_arbiter_lane (
  input  logic [63:0] word,
  input  logic        vld,
  output logic        cand,
  output logic        irq
);
  assign cand = vld;
  assign irq  = vld & word[63];
endmodule

module bus_arbiter #(
  parameter int         NREQ       = 4,
  parameter logic [1:0] RR_INIT    = 2'd0,
  parameter int         TURNAROUND = 1
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  logic [NREQ-1:0][63:0] req_word;
  logic [NREQ-1:0]       cand, irq, pri;

  assign req_word[0] = bus.i_bus0;
  assign req_word[1] = bus.i_bus1;
  assign req_word[2] = bus.i_bus2;
  assign req_word[3] = bus.i_bus3;

  for (genvar n = 0; n < NREQ; n++) begin : g_lane
    bus_arbiter_lane u_lane (
      .word (req_word[n]),
      .vld  (bus.i_vld[n]),
      .cand (cand[n]),
      .irq  (irq[n])
    );
  end

  state_t          state, state_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [63:0]     bus_q, bus_n;
  logic [1:0]      owner, owner_n;
  logic [1:0]      rr_ptr, rr_n;
  logic [2:0]      cnt, cnt_n;
  logic [1:0]      win, idx;
  logic            found;

  // Interrupt requests mask out normal ones; then scan from rr_ptr.
  assign pri = (|irq) ? irq : cand;

  always_comb begin
    win   = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && pri[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    bus_n   = bus_q;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_n = GRANT;
          gnt_n   = NREQ'(1) << win;
          bus_n   = req_word[win];
          owner_n = win;
          cnt_n   = req_word[win][62:60];
        end
      end
      GRANT: begin
        // Owner dropping valid aborts the window early.
        if (cnt == 3'd0 || !bus.i_vld[owner]) begin
          state_n = RELEASE;
          gnt_n   = '0;
          bus_n   = '0;
          rr_n    = owner + 2'd1;
          cnt_n   = 3'(TURNAROUND - 1);
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      RELEASE: begin
        if (cnt == 3'd0) state_n = IDLE;
        else             cnt_n   = cnt - 3'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      bus_q  <= '0;
      owner  <= 2'd0;
      rr_ptr <= RR_INIT;
      cnt    <= 3'd0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      bus_q  <= bus_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
      cnt    <= cnt_n;
    end
  end

  assign bus.o_gnt     = gnt;
  assign bus.o_bus     = bus_q;
  assign bus.o_bus_vld = |gnt;
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_owner   = owner;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared against an ownership-window reference model.
module tb_bus_arbiter;
  localparam int TURN = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld = '0;
  logic [63:0] bw [4];
  int checks = 0;
  int errors = 0;

  bus_arbiter_if bif ();
  assign bif.i_bus0 = bw[0];
  assign bif.i_bus1 = bw[1];
  assign bif.i_bus2 = bw[2];
  assign bif.i_bus3 = bw[3];
  assign bif.i_vld  = vld;

  bus_arbiter #(.NREQ(4), .RR_INIT(2'd0), .TURNAROUND(TURN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = free, 1 = owned, 2 = turnaround
  int          m_phase, m_owner, m_rr, m_held, m_len, m_turn;
  logic [3:0]  m_gnt;
  logic [63:0] m_bus;

  function automatic logic [63:0] mk(input logic irq, input int req, input logic [31:0] data);
    logic [2:0] r;
    r = 3'(req);
    return {irq, r, 28'h0, data};
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_phase = 0; m_owner = 0; m_rr = 0; m_gnt = '0; m_bus = '0;
      m_held = 0; m_len = 0; m_turn = 0;
    end else if (m_phase == 0) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && vld[(m_rr + k) % 4] && bw[(m_rr + k) % 4][63]) w = (m_rr + k) % 4;
      for (int k = 0; k < 4; k++)
        if (w < 0 && vld[(m_rr + k) % 4]) w = (m_rr + k) % 4;
      if (w >= 0) begin
        m_phase = 1; m_owner = w; m_gnt = 4'(1 << w); m_bus = bw[w];
        m_len = int'(bw[w][62:60]) + 1; m_held = 1;
      end
    end else if (m_phase == 1) begin
      if (m_held == m_len || !vld[m_owner]) begin
        m_phase = 2; m_gnt = '0; m_bus = '0; m_rr = (m_owner + 1) % 4; m_turn = TURN;
      end else begin
        m_held++;
      end
    end else begin
      m_turn--;
      if (m_turn == 0) m_phase = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vld = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vld = 4'b1111;
    for (int i = 0; i < 4; i++) bw[i] = mk(1'b0, 0, 32'h1000 + 32'(i));
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bif.o_gnt !== 4'b0 || bif.o_bus !== 64'h0 || bif.o_bus_vld !== 1'b0 ||
          bif.o_busy !== 1'b0 || bif.o_owner !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b bus=%h vld=%b busy=%b owner=%0d want all zero",
                 bif.o_gnt, bif.o_bus, bif.o_bus_vld, bif.o_busy, bif.o_owner);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", bif.o_gnt);
    end
    drain();
  endtask

  task automatic test_single();
    bw[2] = mk(1'b0, 3, 32'hDEAD_BEEF);
    vld = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bif.o_gnt !== 4'b0100 || bif.o_bus[31:0] !== 32'hDEAD_BEEF || bif.o_bus_vld !== 1'b1) begin
        errors++;
        $display("FAIL single_grant[%0d]: gnt=%b data=%h vld=%b want 0100 deadbeef 1",
                 c, bif.o_gnt, bif.o_bus[31:0], bif.o_bus_vld);
      end
    end
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0 || bif.o_bus !== 64'h0 || bif.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_release: gnt=%b bus=%h busy=%b want 0 0 1", bif.o_gnt, bif.o_bus, bif.o_busy);
    end
    vld = '0;
    tick();
    checks++;
    if (bif.o_busy !== 1'b0 || bif.o_gnt !== 4'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b gnt=%b want 0 0", bif.o_busy, bif.o_gnt);
    end
    drain();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bw[i] = mk(1'b0, 0, 32'h2000 + 32'(i));
    vld = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if (bif.o_gnt !== 4'(1 << (g % 4))) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %b want %b", g, bif.o_gnt, 4'(1 << (g % 4)));
      end
      tick();
      checks++;
      if (bif.o_gnt !== 4'b0 || bif.o_busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_release[%0d]: gnt=%b busy=%b want 0 1", g, bif.o_gnt, bif.o_busy);
      end
      tick();
      checks++;
      if (bif.o_gnt !== 4'b0 || bif.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle[%0d]: gnt=%b busy=%b want 0 0", g, bif.o_gnt, bif.o_busy);
      end
    end
    drain();
  endtask

  task automatic test_interrupt();
    // rr_ptr is 1 here, so requester 1 would win without the interrupt flag
    bw[1] = mk(1'b0, 0, 32'h1111_1111);
    bw[2] = mk(1'b1, 0, 32'h2222_2222);
    vld = 4'b0110;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0100 || bif.o_bus !== bw[2]) begin
      errors++;
      $display("FAIL irq_first: gnt=%b bus=%h want 0100 %h", bif.o_gnt, bif.o_bus, bw[2]);
    end
    tick();
    vld = 4'b0010;
    tick();
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0010 || bif.o_owner !== 2'd1) begin
      errors++;
      $display("FAIL irq_second: gnt=%b owner=%0d want 0010 1", bif.o_gnt, bif.o_owner);
    end
    drain();
  endtask

  task automatic test_abort();
    bw[3] = mk(1'b0, 7, 32'h3333_3333);
    vld = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bif.o_gnt !== 4'b1000) begin
        errors++;
        $display("FAIL abort_hold[%0d]: got %b want 1000", c, bif.o_gnt);
      end
    end
    vld = 4'b0000;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0 || bif.o_bus_vld !== 1'b0 || bif.o_owner !== 2'd3) begin
      errors++;
      $display("FAIL abort_drop: gnt=%b vld=%b owner=%0d want 0 0 3", bif.o_gnt, bif.o_bus_vld, bif.o_owner);
    end
    drain();
    for (int i = 0; i < 4; i++) bw[i] = mk(1'b0, 0, 32'h4000 + 32'(i));
    vld = 4'b1111;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL abort_rr_next: got %b want 0001", bif.o_gnt);
    end
    drain();
  endtask

  task automatic test_midgrant_reset();
    logic [63:0] held;
    bw[1] = mk(1'b0, 5, 32'hAAAA_AAAA);
    held  = bw[1];
    vld = 4'b0010;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_grant: got %b want 0010", bif.o_gnt);
    end
    bw[1] = mk(1'b0, 5, 32'h5555_5555);
    tick();
    checks++;
    if (bif.o_bus !== held) begin
      errors++;
      $display("FAIL mid_latch: got %h want %h", bif.o_bus, held);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0 || bif.o_bus !== 64'h0 || bif.o_bus_vld !== 1'b0 ||
        bif.o_busy !== 1'b0 || bif.o_owner !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b bus=%h vld=%b busy=%b owner=%0d want all zero",
               bif.o_gnt, bif.o_bus, bif.o_bus_vld, bif.o_busy, bif.o_owner);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bw[i] = mk(1'b0, 0, 32'h5000 + 32'(i));
    vld = 4'b1111;
    tick();
    checks++;
    if (bif.o_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_rr_init: got %b want 0001", bif.o_gnt);
    end
    drain();
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) vld[i] = ~vld[i];
        bw[i] = {($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 28'($urandom), 32'($urandom)};
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (bif.o_gnt !== m_gnt || bif.o_bus !== m_bus || bif.o_bus_vld !== (|m_gnt) ||
          bif.o_busy !== (m_phase != 0) || bif.o_owner !== 2'(m_owner)) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b bus=%h vld=%b busy=%b owner=%0d want %b %h %b %b %0d",
                 c, bif.o_gnt, bif.o_bus, bif.o_bus_vld, bif.o_busy, bif.o_owner,
                 m_gnt, m_bus, |m_gnt, m_phase != 0, m_owner);
      end
      checks++;
      if (!$onehot0(bif.o_gnt)) begin
        errors++;
        $display("FAIL random_onehot[%0d]: got %b want one-hot or zero", c, bif.o_gnt);
      end
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) bw[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_interrupt();
    test_abort();
    test_midgrant_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
